// File: rtl/ingress_pkg.sv
// Shared defaults and type helpers for the ingress FIFO slice.
package ingress_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 8;

   typedef logic [15:0] stall_cnt_t;

   // Pointer width: index bits plus one wrap bit, so full and empty stay distinguishable
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ingress_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port, no reset.
module ingress_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ingress_fifo.sv
// First-word fall-through valid/ready buffer with occupancy and threshold flags.
// Optional stall counter enabled by INGRESS_FIFO_STALL_CNT_EN.
module ingress_fifo
   import ingress_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int DEPTH        = DEF_DEPTH,
   parameter int AFULL_THRESH = DEPTH - 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_W-1:0]         s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic [ptr_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full
`ifdef INGRESS_FIFO_STALL_CNT_EN
   ,
   output stall_cnt_t                stall_cnt
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] AF_LVL = PW'(AFULL_THRESH);

   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] rdata;
   logic              push;
   logic              pop;

   // Flags come from registered pointers only, so m_ready never reaches s_ready
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign almost_full = (count >= AF_LVL);
   assign s_ready = !full;
   assign m_valid = !empty;
   assign m_data  = empty ? '0 : rdata;

   assign push = s_valid && s_ready;
   assign pop  = m_valid && m_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   ingress_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );

`ifdef INGRESS_FIFO_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (s_valid && !s_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ingress_fifo.sv
// Randomized self-checking bench for ingress_fifo against a queue-based reference model.
module tb_ingress_fifo;
   import ingress_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;
   localparam int AF    = DEPTH - 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [DW-1:0] s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          almost_full;
`ifdef INGRESS_FIFO_STALL_CNT_EN
   stall_cnt_t    stall_cnt;
`endif

   ingress_fifo #(
      .DATA_W       (DW),
      .DEPTH        (DEPTH),
      .AFULL_THRESH (AF)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
`ifdef INGRESS_FIFO_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] q [$];
   int unsigned   stall_m = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      int sz;
      sz = q.size();
      chk("s_ready",     32'(s_ready),     32'(sz < DEPTH));
      chk("m_valid",     32'(m_valid),     32'(sz != 0));
      chk("m_data",      32'(m_data),      (sz != 0) ? 32'(q[0]) : 32'd0);
      chk("count",       32'(count),       32'(sz));
      chk("full",        32'(full),        32'(sz == DEPTH));
      chk("empty",       32'(empty),       32'(sz == 0));
      chk("almost_full", 32'(almost_full), 32'(sz >= AF));
`ifdef INGRESS_FIFO_STALL_CNT_EN
      chk("stall_cnt",   32'(stall_cnt),   32'(stall_m));
`endif
   endtask

   // Inputs are already driven; checks then advances one clock and updates the model
   task automatic step();
      bit push;
      bit pop;
      check_outputs();
      push = s_valid && (q.size() < DEPTH);
      pop  = m_ready && (q.size() != 0);
      if (s_valid && q.size() == DEPTH && stall_m != 32'hFFFF) stall_m++;
      @(posedge clk);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(s_data);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      q.delete();
      stall_m = 0;
      #1;
      check_outputs();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b1;
   endtask

   initial begin
      int budget;

      // Power-on reset
      #1;
      do_reset();

      // Fill with 0x01..0x08, then one refused push while full
      m_ready = 1'b0;
      for (int i = 1; i <= DEPTH + 1; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i);
         step();
      end
      chk("fill_full", 32'(full), 32'd1);

      // Full: pop with no push on first edge, pending word lands next edge
      m_ready = 1'b1;
      s_data  = 8'h09;
      step();
      chk("full_pop_count", 32'(count), 32'd7);
      m_ready = 1'b0;
      step();
      chk("refill_count", 32'(count), 32'd8);

      // Drain in order
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      chk("drain_empty", 32'(empty), 32'd1);

      // Streaming from empty
      s_valid = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         s_data = 8'(i);
         step();
         chk("stream_count", 32'(count), 32'd1);
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      step();
      step();

      // Random traffic with wrap
      for (int i = 0; i < 400; i++) begin
         s_valid = 1'($urandom_range(0, 99) < 60);
         m_ready = 1'($urandom_range(0, 99) < 45);
         s_data  = 8'($urandom);
         step();
      end

      // Steer to occupancy 5 then reset mid-stream
      budget = 0;
      while (q.size() != 5 && budget < 200) begin
         s_valid = 1'(q.size() < 5);
         m_ready = 1'(q.size() > 5);
         s_data  = 8'($urandom);
         step();
         budget++;
      end
      chk("reach_cnt5", 32'(q.size()), 32'd5);
      s_valid = 1'b1;
      m_ready = 1'b0;
      do_reset();
      s_valid = 1'b1;
      s_data  = 8'hAA;
      step();
      chk("head_aa", 32'(m_data), 32'hAA);
      s_valid = 1'b0;
      step();

`ifdef INGRESS_FIFO_STALL_CNT_EN
      // Stall counter: fill, then 10 refused cycles
      do_reset();
      m_ready = 1'b0;
      s_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         s_data = 8'($urandom);
         step();
      end
      for (int i = 0; i < 10; i++) step();
      chk("stall_10", 32'(stall_cnt), 32'd10);
      s_valid = 1'b0;
      do_reset();
      chk("stall_clr", 32'(stall_cnt), 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
